// File: rtl/demux1to4_stream.sv
// One-to-four stream demux: each input beat is steered by sel_i into a one-entry output register per channel.
// Latency: 1 cycle from input transfer to valid_o. Backpressure: ready_o follows only the selected channel's slot state and its ready_i.
// Optional per-channel 16-bit accepted-beat counters (cnt_o) are enabled with DEMUX4_CNT_EN.
module demux1to4_stream #(
    parameter int DATA_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic [1:0]             sel_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [3:0][DATA_W-1:0] data_o,
    output logic [3:0]             valid_o,
    input  logic [3:0]             ready_i
`ifdef DEMUX4_CNT_EN
    ,
    output logic [3:0][15:0]       cnt_o
`endif
);

    logic       in_xfer;
    logic [3:0] load;

    // A slot can take a new beat when it is empty or is draining this same cycle.
    assign ready_o = ~valid_o[sel_i] | ready_i[sel_i];
    assign in_xfer = valid_i & ready_o;

    always_comb begin
        load = 4'b0000;
        if (in_xfer) begin
            load[sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 4'b0000;
            data_o  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_o[k]  <= data_i;
                    valid_o[k] <= 1'b1;
                end else if (ready_i[k]) begin
                    valid_o[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX4_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    cnt_o[k] <= cnt_o[k] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
